// File: rtl/uart_regif.sv
// UART register file on the memory side of the APB bridge.
// Registered ack/rdata/resp one cycle after each single-cycle request.
module uart_regif #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_CNT_W = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mreq_i,
    input  logic [ADDR_WIDTH-1:0]   maddr_i,
    input  logic                    mwe_i,
    input  logic [DATA_WIDTH-1:0]   mwdata_i,
    input  logic [DATA_WIDTH/8-1:0] mstrb_i,
    output logic                    mack_o,
    output logic [DATA_WIDTH-1:0]   mrdata_o,
    output logic                    mresp_o,
    output logic [7:0]              tx_data_o,
    output logic                    tx_push_o,
    input  logic                    tx_full_i,
    input  logic [FIFO_CNT_W-1:0]   tx_count_i,
    input  logic [7:0]              rx_data_i,
    output logic                    rx_pop_o,
    input  logic [FIFO_CNT_W-1:0]   rx_count_i,
    output logic                    tx_en_o,
    output logic                    rx_en_o,
    output logic                    tx_flush_o,
    output logic                    rx_flush_o,
    output logic                    parity_en_o,
    output logic                    parity_odd_o,
    output logic                    stop2_o,
    output logic [31:0]             clk_div_o,
    output logic                    irq_o
);

    localparam logic [2:0] OFF_CTRL  = 3'd0;
    localparam logic [2:0] OFF_CFG   = 3'd1;
    localparam logic [2:0] OFF_DIV   = 3'd2;
    localparam logic [2:0] OFF_INTEN = 3'd3;
    localparam logic [2:0] OFF_STAT  = 3'd4;
    localparam logic [2:0] OFF_TX    = 3'd5;
    localparam logic [2:0] OFF_RX    = 3'd6;

    logic [1:0]            r_ctrl;
    logic [2:0]            r_cfg;
    logic [31:0]           r_clk_div;
    logic [1:0]            r_int_en;
    logic                  r_tx_flush;
    logic                  r_rx_flush;
    logic                  r_ack;
    logic                  r_resp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_irq;

    logic                  w_oor;
    logic [2:0]            w_off;
    logic                  w_rx_has;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_err;
    logic                  w_wr_ok;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_addr;

    assign w_oor         = |maddr_i[ADDR_WIDTH-1:5];
    assign w_off         = maddr_i[4:2];
    assign w_rx_has      = (rx_count_i != '0);
    assign w_wr          = mreq_i & mwe_i & ~rst_i;
    assign w_rd          = mreq_i & ~mwe_i & ~rst_i;
    assign w_unused_addr = ^maddr_i[1:0];

    // Decode error and read data; errors and writes always return zero.
    always_comb begin
        w_err   = 1'b0;
        w_rdata = '0;
        case (w_off)
            OFF_CTRL:  w_rdata[1:0] = r_ctrl;
            OFF_CFG:   w_rdata[2:0] = r_cfg;
            OFF_DIV:   w_rdata[31:0] = r_clk_div;
            OFF_INTEN: w_rdata[1:0] = r_int_en;
            OFF_STAT: begin
                w_rdata[FIFO_CNT_W-1:0]  = tx_count_i;
                w_rdata[16+:FIFO_CNT_W]  = rx_count_i;
                w_rdata[31]              = tx_full_i;
                w_err                    = mwe_i;
            end
            OFF_TX:    w_err = ~mwe_i | ~mstrb_i[0] | tx_full_i;
            OFF_RX: begin
                w_rdata[7:0] = rx_data_i;
                w_err        = mwe_i | ~w_rx_has;
            end
            default:   w_err = 1'b1;
        endcase
        if (w_oor) begin
            w_err = 1'b1;
        end
        if (w_err || mwe_i) begin
            w_rdata = '0;
        end
    end

    assign w_wr_ok = w_wr & ~w_err;
    assign w_push  = w_wr_ok & (w_off == OFF_TX);
    assign w_pop   = w_rd & ~w_err & (w_off == OFF_RX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl     <= '0;
            r_cfg      <= '0;
            r_clk_div  <= '0;
            r_int_en   <= '0;
            r_tx_flush <= 1'b0;
            r_rx_flush <= 1'b0;
            r_ack      <= 1'b0;
            r_resp     <= 1'b0;
            r_rdata    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_ack      <= mreq_i;
            r_tx_flush <= 1'b0;
            r_rx_flush <= 1'b0;
            if (mreq_i) begin
                r_rdata <= w_rdata;
                r_resp  <= w_err;
            end
            if (w_wr_ok) begin
                case (w_off)
                    OFF_CTRL: if (mstrb_i[0]) begin
                        r_ctrl     <= mwdata_i[1:0];
                        r_tx_flush <= mwdata_i[2];
                        r_rx_flush <= mwdata_i[3];
                    end
                    OFF_CFG: if (mstrb_i[0]) begin
                        r_cfg <= mwdata_i[2:0];
                    end
                    OFF_DIV: begin
                        for (int b = 0; b < 4; b++) begin
                            if (mstrb_i[b]) begin
                                r_clk_div[8*b+:8] <= mwdata_i[8*b+:8];
                            end
                        end
                    end
                    OFF_INTEN: if (mstrb_i[0]) begin
                        r_int_en <= mwdata_i[1:0];
                    end
                    default: ;
                endcase
            end
            r_irq <= (r_int_en[0] & (tx_count_i == '0)) |
                     (r_int_en[1] & w_rx_has);
        end
    end

    // Reset forces every output low, including an ack already in flight.
    assign mack_o       = r_ack & ~rst_i;
    assign mresp_o      = r_resp & ~rst_i;
    assign mrdata_o     = rst_i ? '0 : r_rdata;
    assign tx_push_o    = w_push;
    assign tx_data_o    = w_push ? mwdata_i[7:0] : 8'h00;
    assign rx_pop_o     = w_pop;
    assign tx_en_o      = r_ctrl[0] & ~rst_i;
    assign rx_en_o      = r_ctrl[1] & ~rst_i;
    assign tx_flush_o   = r_tx_flush & ~rst_i;
    assign rx_flush_o   = r_rx_flush & ~rst_i;
    assign parity_en_o  = r_cfg[0] & ~rst_i;
    assign parity_odd_o = r_cfg[1] & ~rst_i;
    assign stop2_o      = r_cfg[2] & ~rst_i;
    assign clk_div_o    = rst_i ? 32'h0 : r_clk_div;
    assign irq_o        = r_irq & ~rst_i;

endmodule

// File: tb/tb_uart_regif.sv
// Bench for uart_regif: vector table through a scoreboard,
// plus flush, interrupt, idle-gating and mid-request reset sequences.
module tb_uart_regif;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          mreq;
    logic [AW-1:0] maddr;
    logic          mwe;
    logic [DW-1:0] mwdata;
    logic [3:0]    mstrb;
    logic          mack_o;
    logic [DW-1:0] mrdata_o;
    logic          mresp_o;
    logic [7:0]    tx_data_o;
    logic          tx_push_o;
    logic          tx_full;
    logic [CW-1:0] tx_count;
    logic [7:0]    rx_data;
    logic          rx_pop_o;
    logic [CW-1:0] rx_count;
    logic          tx_en_o, rx_en_o, tx_flush_o, rx_flush_o;
    logic          parity_en_o, parity_odd_o, stop2_o;
    logic [31:0]   clk_div_o;
    logic          irq_o;

    always #5 clk = ~clk;

    uart_regif #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .mreq_i(mreq), .maddr_i(maddr),
        .mwe_i(mwe), .mwdata_i(mwdata), .mstrb_i(mstrb),
        .mack_o(mack_o), .mrdata_o(mrdata_o), .mresp_o(mresp_o),
        .tx_data_o(tx_data_o), .tx_push_o(tx_push_o),
        .tx_full_i(tx_full), .tx_count_i(tx_count),
        .rx_data_i(rx_data), .rx_pop_o(rx_pop_o), .rx_count_i(rx_count),
        .tx_en_o(tx_en_o), .rx_en_o(rx_en_o),
        .tx_flush_o(tx_flush_o), .rx_flush_o(rx_flush_o),
        .parity_en_o(parity_en_o), .parity_odd_o(parity_odd_o),
        .stop2_o(stop2_o), .clk_div_o(clk_div_o), .irq_o(irq_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        full;
        logic [4:0]  txc;
        logic [4:0]  rxc;
        logic [7:0]  rxd;
        logic [31:0] erd;
        logic        eresp;
        logic        epush;
        logic        epop;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        resp;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mack_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_cycle", 64'(cyc), 64'(e.cyc + 1));
                chk("rdata", 64'(mrdata_o), 64'(e.rd));
                chk("resp", 64'(mresp_o), 64'(e.resp));
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input logic full, input logic [4:0] txc,
                                input logic [4:0] rxc, input logic [7:0] rxd,
                                input logic [31:0] erd, input logic eresp,
                                input logic epush, input logic epop);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.full = full; v.txc = txc; v.rxc = rxc; v.rxd = rxd;
        v.erd = erd; v.eresp = eresp; v.epush = epush; v.epop = epop;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the next one.
    task automatic req(input vec_t v);
        exp_t e;
        mreq = 1'b1; mwe = v.we; maddr = v.addr; mwdata = v.wdata;
        mstrb = v.strb; tx_full = v.full; tx_count = v.txc;
        rx_count = v.rxc; rx_data = v.rxd;
        @(negedge clk);
        chk("tx_push", 64'(tx_push_o), 64'(v.epush));
        chk("rx_pop", 64'(rx_pop_o), 64'(v.epop));
        if (v.epush) chk("tx_data", 64'(tx_data_o), 64'(v.wdata[7:0]));
        e.rd = v.erd; e.resp = v.eresp; e.cyc = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        mreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mreq = 1'b0; maddr = '0; mwe = 1'b0; mwdata = '0;
        mstrb = '0; tx_full = 1'b0; tx_count = 5'd1; rx_count = '0;
        rx_data = '0;

        // we addr wdata strb full txc rxc rxd | rdata resp push pop
        tbl.push_back(mk(1, 32'h08, 32'h0000_1A2B, 4'hF, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h08, 32'hFFFF_FFFF, 4'h2, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h08, 32'h0, 4'h0, 0, 1, 0, 8'h00, 32'h0000_FF2B, 0, 0, 0));
        tbl.push_back(mk(1, 32'h14, 32'h0000_005A, 4'h1, 0, 1, 0, 8'h00, 32'h0, 0, 1, 0));
        tbl.push_back(mk(1, 32'h14, 32'h0000_005A, 4'h1, 1, 1, 0, 8'h00, 32'h0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h14, 32'h0000_7777, 4'h2, 0, 1, 0, 8'h00, 32'h0, 1, 0, 0));
        tbl.push_back(mk(0, 32'h18, 32'h0, 4'h0, 0, 1, 3, 8'hC3, 32'h0000_00C3, 0, 0, 1));
        tbl.push_back(mk(0, 32'h18, 32'h0, 4'h0, 0, 1, 0, 8'hC3, 32'h0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h10, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, 8'h00, 32'h0, 1, 0, 0));
        tbl.push_back(mk(0, 32'h14, 32'h0, 4'h0, 0, 1, 0, 8'h00, 32'h0, 1, 0, 0));
        tbl.push_back(mk(0, 32'h1C, 32'h0, 4'h0, 0, 1, 0, 8'h00, 32'h0, 1, 0, 0));
        tbl.push_back(mk(0, 32'h20, 32'h0, 4'h0, 0, 1, 0, 8'h00, 32'h0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h8000_0008, 32'h1111_1111, 4'hF, 0, 1, 0, 8'h00, 32'h0, 1, 0, 0));
        tbl.push_back(mk(0, 32'h08, 32'h0, 4'h0, 0, 1, 0, 8'h00, 32'h0000_FF2B, 0, 0, 0));
        tbl.push_back(mk(1, 32'h04, 32'h0000_00FF, 4'h1, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h04, 32'h0, 4'h0, 0, 1, 0, 8'h00, 32'h0000_0007, 0, 0, 0));
        tbl.push_back(mk(0, 32'h10, 32'h0, 4'h0, 1, 5, 9, 8'h00, 32'h8009_0005, 0, 0, 0));
        tbl.push_back(mk(1, 32'h0C, 32'hFFFF_FFFF, 4'hE, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0C, 32'h0, 4'h0, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0B, 32'h0, 4'h0, 0, 1, 0, 8'h00, 32'h0000_FF2B, 0, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 64'(mack_o), 64'd0);
        chk("rst_outs", 64'({mresp_o, mrdata_o, tx_push_o, rx_pop_o, irq_o,
                            tx_en_o, rx_en_o, tx_flush_o, rx_flush_o}), 64'd0);
        chk("rst_div", 64'(clk_div_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) req(tbl[i]);

        chk("clk_div_o", 64'(clk_div_o), 64'h0000_FF2B);
        chk("cfg_outs", 64'({stop2_o, parity_odd_o, parity_en_o}), 64'b111);

        // Flush pulses exactly once, CTRL keeps only the enables.
        req(mk(1, 32'h00, 32'h0000_000F, 4'h1, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0));
        @(negedge clk);
        chk("flush_pulse", 64'({tx_flush_o, rx_flush_o}), 64'b11);
        chk("enables", 64'({tx_en_o, rx_en_o}), 64'b11);
        @(negedge clk);
        chk("flush_end", 64'({tx_flush_o, rx_flush_o}), 64'b00);
        @(posedge clk); #1;
        req(mk(0, 32'h00, 32'h0, 4'h0, 0, 1, 0, 8'h00, 32'h0000_0003, 0, 0, 0));

        // Interrupt on rx_not_empty.
        req(mk(1, 32'h0C, 32'h0000_0002, 4'h1, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0));
        repeat (2) @(negedge clk);
        chk("irq_idle", 64'(irq_o), 64'd0);
        @(posedge clk); #1;
        rx_count = 5'd1;
        @(negedge clk);
        chk("irq_lag", 64'(irq_o), 64'd0);
        @(negedge clk);
        chk("irq_rx", 64'(irq_o), 64'd1);
        @(posedge clk); #1;
        rx_count = 5'd0;
        repeat (2) @(negedge clk);
        chk("irq_fall", 64'(irq_o), 64'd0);

        // Interrupt on tx_empty.
        @(posedge clk); #1;
        req(mk(1, 32'h0C, 32'h0000_0001, 4'h1, 0, 3, 0, 8'h00, 32'h0, 0, 0, 0));
        repeat (2) @(negedge clk);
        chk("irq_tx_busy", 64'(irq_o), 64'd0);
        @(posedge clk); #1;
        tx_count = 5'd0;
        repeat (2) @(negedge clk);
        chk("irq_tx_empty", 64'(irq_o), 64'd1);

        // No side effects without a request.
        @(posedge clk); #1;
        mreq = 1'b0; mwe = 1'b1; maddr = 32'h14; mwdata = 32'hA5;
        mstrb = 4'h1; tx_full = 1'b0;
        @(negedge clk);
        chk("idle_push", 64'(tx_push_o), 64'd0);
        @(posedge clk); #1;
        mwe = 1'b0; maddr = 32'h18; rx_count = 5'd3;
        @(negedge clk);
        chk("idle_pop", 64'(rx_pop_o), 64'd0);
        @(posedge clk); #1;
        rx_count = 5'd0;

        // Reset in the cycle after a write kills the ack and the write.
        mreq = 1'b1; mwe = 1'b1; maddr = 32'h08; mwdata = 32'hDEAD_BEEF;
        mstrb = 4'hF;
        @(posedge clk); #1;
        mreq = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack", 64'(mack_o), 64'd0);
        chk("rst_mid_outs", 64'({mresp_o, mrdata_o, tx_push_o, rx_pop_o,
                                irq_o, tx_en_o, rx_en_o}), 64'd0);
        chk("rst_mid_div", 64'(clk_div_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ack", 64'(mack_o), 64'd0);
        chk("post_rst_div", 64'(clk_div_o), 64'd0);
        chk("post_rst_en", 64'({tx_en_o, rx_en_o, irq_o}), 64'd0);
        @(posedge clk); #1;
        req(mk(0, 32'h08, 32'h0, 4'h0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
